// File: rtl/ssp_tx_fifo_pkg.sv
// Shared SSP FIFO constants and types, common to the TX and RX FIFO slices.
// Sizes are fixed: eight 16-bit entries with 3-bit pointers and a 4-bit count.
package ssp_tx_fifo_pkg;

  localparam int FIFO_DEPTH   = 8;
  localparam int FIFO_WIDTH   = 16;
  localparam int PTR_W        = 3;
  localparam int CNT_W        = 4;
  localparam int TXRIS_THRESH = 4;

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [FIFO_WIDTH-1:0] word_t;

  localparam cnt_t FULL_CNT   = cnt_t'(FIFO_DEPTH);
  localparam cnt_t THRESH_CNT = cnt_t'(TXRIS_THRESH);

  // Registered-state decodes handed from the control block to the top.
  typedef struct packed {
    logic tfe;
    logic tnf;
    logic txris;
    cnt_t level;
  } fifo_status_t;

  // Depth is a power of two, so the natural pointer overflow is the wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/ssp_tx_fifo_if.sv
// APB-side data/strobe bundle and status outputs of the SSP transmit FIFO.
interface ssp_tx_fifo_if;
  import ssp_tx_fifo_pkg::*;

  word_t PWDATAIn;
  logic  SSPDRWr;
  logic  TxFRdPtrInc;
  logic  TESTFIFO;
  logic  SSPTDRRd;
  logic  TXIM;

  word_t TxFRdData;
  logic  TFE;
  logic  TNF;
  logic  TXRIS;
  logic  TXMIS;
  cnt_t  TxFLevel;

  modport master (
    output PWDATAIn, SSPDRWr, TxFRdPtrInc, TESTFIFO, SSPTDRRd, TXIM,
    input  TxFRdData, TFE, TNF, TXRIS, TXMIS, TxFLevel
  );

  modport slave (
    input  PWDATAIn, SSPDRWr, TxFRdPtrInc, TESTFIFO, SSPTDRRd, TXIM,
    output TxFRdData, TFE, TNF, TXRIS, TXMIS, TxFLevel
  );

endinterface

// File: rtl/ssp_tx_fcntl.sv
// Pointer, occupancy and status control for the SSP transmit FIFO.
// Push/pop qualification uses the count before this cycle's update.
module ssp_tx_fcntl
  import ssp_tx_fifo_pkg::*;
(
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic         push_req,
  input  logic         pop_req,
  output logic         push_en,
  output logic         pop_en,
  output ptr_t         wr_ptr,
  output ptr_t         rd_ptr,
  output fifo_status_t status
);

  cnt_t count;

  // Full is judged before any pop, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle; likewise for empty/pop.
  always_comb begin
    push_en = push_req && (count != FULL_CNT);
    pop_en  = pop_req  && (count != '0);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push_en, pop_en})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    status       = '0;
    status.tfe   = (count == '0);
    status.tnf   = (count != FULL_CNT);
    status.txris = (count <= THRESH_CNT);
    status.level = count;
  end

endmodule

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: 8x16 register file with APB push side and serializer/test pop side.
// Read data is an unregistered view of the entry at the read pointer.
module ssp_tx_fifo
  import ssp_tx_fifo_pkg::*;
(
  input  logic          PCLK,
  input  logic          PRESETn,
  ssp_tx_fifo_if.slave  bus
);

  word_t        mem [FIFO_DEPTH];
  ptr_t         wr_ptr;
  ptr_t         rd_ptr;
  logic         push_en;
  logic         pop_en;
  logic         pop_req;
  fifo_status_t status;

  // Test mode hands the pop to the test data register read; the other strobe is ignored.
  assign pop_req = bus.TESTFIFO ? bus.SSPTDRRd : bus.TxFRdPtrInc;

  ssp_tx_fcntl u_fcntl (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .push_req (bus.SSPDRWr),
    .pop_req  (pop_req),
    .push_en  (push_en),
    .pop_en   (pop_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .status   (status)
  );

  // Entries are cleared on reset so read data comes up as zero.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_en) begin
      mem[wr_ptr] <= bus.PWDATAIn;
    end
  end

  always_comb begin
    bus.TxFRdData = mem[rd_ptr];
    bus.TFE       = status.tfe;
    bus.TNF       = status.tnf;
    bus.TXRIS     = status.txris;
    bus.TXMIS     = status.txris & bus.TXIM;
    bus.TxFLevel  = status.level;
  end

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Self-checking bench for ssp_tx_fifo: constant vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_ssp_tx_fifo;
  import ssp_tx_fifo_pkg::*;

  logic PCLK = 1'b0;
  logic PRESETn;

  ssp_tx_fifo_if bus ();

  ssp_tx_fifo dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  logic [15:0] modelQ [$];

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic        pop;
    logic        im;
    logic        chkRd;
    logic [15:0] expRd;
    int          expLevel;
    logic        expTfe;
    logic        expTnf;
    logic        expRis;
    logic        expMis;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] data, input logic inc,
                               input logic tf, input logic tdr, input logic im);
    bus.SSPDRWr     = wr;
    bus.PWDATAIn    = data;
    bus.TxFRdPtrInc = inc;
    bus.TESTFIFO    = tf;
    bus.SSPTDRRd    = tdr;
    bus.TXIM        = im;
  endtask

  // Status expected from the model occupancy alone.
  task automatic checkModelStatus(input string tag, input logic im);
    int lvl;
    lvl = modelQ.size();
    checkOutput({tag, "_level"}, 32'(bus.TxFLevel), 32'(lvl));
    checkOutput({tag, "_tfe"},   32'(bus.TFE),      32'(lvl == 0));
    checkOutput({tag, "_tnf"},   32'(bus.TNF),      32'(lvl != 8));
    checkOutput({tag, "_txris"}, 32'(bus.TXRIS),    32'(lvl <= 4));
    checkOutput({tag, "_txmis"}, 32'(bus.TXMIS),    32'((lvl <= 4) && im));
  endtask

  // One clock of traffic: predicted pop data is compared before the edge,
  // status after it.
  task automatic modelCycle(input string tag, input logic wr, input logic [15:0] data,
                            input logic inc, input logic tf, input logic tdr, input logic im,
                            output logic [15:0] popped, output bit didPop);
    bit doPush;
    applyStimulus(wr, data, inc, tf, tdr, im);
    #1;
    doPush = wr && (modelQ.size() < 8);
    didPop = (tf ? tdr : inc) && (modelQ.size() > 0);
    popped = 16'h0;
    if (didPop) begin
      popped = modelQ[0];
      checkOutput({tag, "_rddata"}, 32'(bus.TxFRdData), 32'(modelQ[0]));
    end
    @(posedge PCLK);
    #1;
    if (didPop) void'(modelQ.pop_front());
    if (doPush) modelQ.push_back(data);
    checkModelStatus(tag, im);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    PRESETn = 1'b0;
    #2;
    checkOutput("rst_level",  32'(bus.TxFLevel),  32'd0);
    checkOutput("rst_tfe",    32'(bus.TFE),       32'd1);
    checkOutput("rst_tnf",    32'(bus.TNF),       32'd1);
    checkOutput("rst_txris",  32'(bus.TXRIS),     32'd1);
    checkOutput("rst_txmis",  32'(bus.TXMIS),     32'd1);
    checkOutput("rst_rddata", 32'(bus.TxFRdData), 32'd0);
    modelQ.delete();
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] p;
    bit          dp;
    bit          sawBeef;

    // Fill-to-full, dropped ninth write, drain in order, then pop on empty.
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{1'b1, 16'(16'h1111 * k), 1'b0, 1'(k % 2), 1'b0, 16'h0,
                       k, 1'b0, (k != 8), (k <= 4), ((k <= 4) && (k % 2 == 1))});
    vecs.push_back('{1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h0, 8, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'(16'h1111 * k),
                       8 - k, (k == 8), 1'b1, ((8 - k) <= 4), ((8 - k) <= 4)});
    vecs.push_back('{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0, 0, 1'b1, 1'b1, 1'b1, 1'b1});

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    PRESETn = 1'b1;
    #1;
    resetDut();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].pop, 1'b0, 1'b0, vecs[i].im);
      #1;
      if (vecs[i].chkRd) checkOutput("tbl_rddata", 32'(bus.TxFRdData), 32'(vecs[i].expRd));
      @(posedge PCLK);
      #1;
      checkOutput("tbl_level", 32'(bus.TxFLevel), 32'(vecs[i].expLevel));
      checkOutput("tbl_tfe",   32'(bus.TFE),      32'(vecs[i].expTfe));
      checkOutput("tbl_tnf",   32'(bus.TNF),      32'(vecs[i].expTnf));
      checkOutput("tbl_txris", 32'(bus.TXRIS),    32'(vecs[i].expRis));
      checkOutput("tbl_txmis", 32'(bus.TXMIS),    32'(vecs[i].expMis));
    end

    // Pop on empty leaves pointers alone: the next push is visible at the read pointer.
    resetDut();
    modelCycle("empty_pop", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, p, dp);
    modelCycle("empty_push", 1'b1, 16'h4242, 1'b0, 1'b0, 1'b0, 1'b1, p, dp);
    checkOutput("empty_ptr_rddata", 32'(bus.TxFRdData), 32'h4242);

    // Full FIFO with simultaneous push and pop: only the pop happens.
    resetDut();
    for (int k = 1; k <= 8; k++)
      modelCycle("fill", 1'b1, 16'(16'h1111 * k), 1'b0, 1'b0, 1'b0, 1'b1, p, dp);
    modelCycle("full_pp", 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, p, dp);
    checkOutput("full_pp_data",  32'(p), 32'h1111);
    checkOutput("full_pp_level", 32'(bus.TxFLevel), 32'd7);
    sawBeef = 1'b0;
    for (int k = 0; k < 8; k++) begin
      modelCycle("full_drain", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, p, dp);
      if (dp && p == 16'hBEEF) sawBeef = 1'b1;
    end
    checkOutput("no_beef", 32'(sawBeef), 32'd0);

    // Empty FIFO with simultaneous push and pop: only the push happens; then wrap traffic.
    resetDut();
    modelCycle("empty_pp", 1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b1, p, dp);
    checkOutput("empty_pp_level", 32'(bus.TxFLevel), 32'd1);
    modelCycle("empty_pp_pop", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, p, dp);
    checkOutput("empty_pp_data", 32'(p), 32'hA5A5);
    for (int i = 0; i < 20; i++)
      modelCycle("wrap", 1'(i % 3 != 2), 16'(16'h0100 + i), 1'(i % 2 == 1),
                 1'b0, 1'b0, 1'b1, p, dp);

    // Test mode selects the test-register read strobe as the pop source.
    resetDut();
    for (int k = 1; k <= 3; k++)
      modelCycle("tm_fill", 1'b1, 16'(16'h3000 + k), 1'b0, 1'b0, 1'b0, 1'b1, p, dp);
    modelCycle("tm_inc", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, p, dp);
    modelCycle("tm_inc", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, p, dp);
    checkOutput("tm_inc_level", 32'(bus.TxFLevel), 32'd3);
    modelCycle("tm_im1", 1'b1, 16'h3004, 1'b0, 1'b1, 1'b0, 1'b1, p, dp);
    modelCycle("tm_im0", 1'b1, 16'h3005, 1'b0, 1'b1, 1'b0, 1'b0, p, dp);
    modelCycle("tm_im1_hi", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, p, dp);
    for (int k = 1; k <= 5; k++) begin
      modelCycle("tm_pop", 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'(k % 2), p, dp);
      checkOutput("tm_pop_order", 32'(p), 32'(16'h3000 + k));
    end

    // Reset mid-operation with a push pending, then restart from entry 0.
    resetDut();
    for (int k = 1; k <= 6; k++)
      modelCycle("pre_rst", 1'b1, 16'(16'h6000 + k), 1'b0, 1'b0, 1'b0, 1'b1, p, dp);
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("mid_rst_level",  32'(bus.TxFLevel),  32'd0);
    checkOutput("mid_rst_tfe",    32'(bus.TFE),       32'd1);
    checkOutput("mid_rst_tnf",    32'(bus.TNF),       32'd1);
    checkOutput("mid_rst_txris",  32'(bus.TXRIS),     32'd1);
    checkOutput("mid_rst_txmis",  32'(bus.TXMIS),     32'd1);
    checkOutput("mid_rst_rddata", 32'(bus.TxFRdData), 32'd0);
    @(posedge PCLK);
    #1;
    checkOutput("mid_rst_hold", 32'(bus.TxFLevel), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    modelQ.delete();
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    modelCycle("post_rst", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, p, dp);
    checkOutput("post_rst_entry0", 32'(bus.TxFRdData), 32'h1234);

    // Randomized traffic against the queue model.
    resetDut();
    for (int i = 0; i < 400; i++)
      modelCycle("rnd", 1'($urandom_range(0, 99) < 55), 16'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p, dp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssp_tx_fifo.md
SSP_TX_FIFO -- requirements
Module: ssp_tx_fifo

Interface
REQ-001 The block SHALL have no parameters; FIFO_DEPTH=8 and FIFO_WIDTH=16 SHALL be fixed constants.
REQ-002 PCLK  in  1  APB clock, the single clock; all state SHALL change on its rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous and active-low.
REQ-004 PWDATAIn  in  16  APB write data for a data-register push.
REQ-005 SSPDRWr  in  1  data-register write strobe (push request).
REQ-006 TxFRdPtrInc  in  1  serializer pop request, normal mode.
REQ-007 TESTFIFO  in  1  test mode enable.
REQ-008 SSPTDRRd  in  1  test data register read strobe (pop request, test mode).
REQ-009 TXIM  in  1  TX interrupt mask; 1 = interrupt enabled.
REQ-010 TxFRdData  out  16  data at the read pointer.
REQ-011 TFE  out  1  FIFO empty.
REQ-012 TNF  out  1  FIFO not full.
REQ-013 TXRIS  out  1  TX raw interrupt status.
REQ-014 TXMIS  out  1  TX masked interrupt status.
REQ-015 TxFLevel  out  4  current occupancy, 0..8.

Function
REQ-016 Storage SHALL be an 8x16 register file with a 3-bit write pointer WrPtr, a 3-bit read pointer RdPtr and a 4-bit count.
REQ-017 The push condition SHALL be SSPDRWr=1 and count<8; on push, PWDATAIn SHALL be written to entry WrPtr and WrPtr SHALL advance by 1 mod 8.
REQ-018 An SSPDRWr with count=8 SHALL be dropped, with no state change and no error flag.
REQ-019 The pop source SHALL be TxFRdPtrInc when TESTFIFO=0 and SSPTDRRd when TESTFIFO=1; the unselected strobe SHALL be ignored.
REQ-020 A pop SHALL occur only when the selected strobe is 1 and count>0; on pop, RdPtr SHALL advance by 1 mod 8.
REQ-021 A pop with count=0 SHALL be ignored.
REQ-022 When push and pop both occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 With count=8, a simultaneous push and pop SHALL perform the pop only (full is evaluated before the pop).
REQ-024 With count=0, a simultaneous push and pop SHALL perform the push only.
REQ-025 Pointers SHALL wrap from 7 to 0 with no other side effect.
REQ-026 TxFRdData SHALL be combinational mem[RdPtr], valid in the same cycle as the pop strobe; it is undefined-but-stable when empty.
REQ-027 TFE=(count==0); TNF=(count!=8); TxFLevel=count; all SHALL be registered-state decodes with no input-to-output paths.
REQ-028 TXRIS SHALL be 1 when count<=4 (FIFO half empty or less) and 0 otherwise.
REQ-029 TXMIS SHALL equal TXRIS AND TXIM.
REQ-030 Status outputs SHALL reflect a push or pop in the cycle after the strobe edge, i.e. 1-cycle latency.

Reset
REQ-031 While PRESETn=0, the block SHALL hold WrPtr=0, RdPtr=0, count=0 and all entries at 0.
REQ-032 The reset values of the outputs SHALL be TFE=1, TNF=1, TXRIS=1, TXMIS=TXIM, TxFLevel=0 and TxFRdData=0.
REQ-033 Reset asserted mid-operation SHALL discard all contents immediately, regardless of pending strobes.

Structure
REQ-034 FIFO_DEPTH, FIFO_WIDTH, the pointer width (3), the count width (4) and the TXRIS threshold (4) SHALL live in a shared SSP package used by the TX and RX FIFOs.
REQ-035 The pointer, count and status logic SHALL be one sub-module, ssp_tx_fcntl; the register file SHALL be inline in ssp_tx_fifo.

Verification
REQ-036 Reset, then push 0x1111..0x8888 (8 writes): TxFLevel=8, TNF=0, TXRIS=0 after write 5; a 9th write of 0xDEAD is dropped and the next 8 pops return 0x1111..0x8888 in order.
REQ-037 Pop on empty after reset: pointers, TFE=1 and TxFLevel=0 are all unchanged.
REQ-038 Fill to 8, then simultaneous push 0xBEEF and pop: the pop returns 0x1111, TxFLevel=7, and 0xBEEF never appears.
REQ-039 Empty FIFO, simultaneous push 0xA5A5 and pop: TxFLevel=1 and the next pop returns 0xA5A5; then run 20 mixed push/pops across the wrap and check data order.
REQ-040 TESTFIFO=1 with 3 entries: TxFRdPtrInc pulses have no effect, and SSPTDRRd pops in order; TXIM toggles TXMIS only while count<=4.
REQ-041 Assert PRESETn=0 with 6 entries mid-push: all outputs take reset values asynchronously, and post-reset pushes restart at entry 0.
